// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA timing on the 25 MHz pixel clock.
// Requests pixels one cycle ahead, then registers sync, RGB and frame pulse.
module vga_timing_gen #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_VALID  = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_VALID  = 480,
    parameter int V_FRONT  = 10,
    parameter bit SYNC_POL = 1'b0,
    parameter int RGB_W    = 16
) (
    input  logic             vga_clk,
    input  logic             sys_rst,
    input  logic [RGB_W-1:0] pix_data,
    output logic             pix_data_req,
    output logic [9:0]       pix_x,
    output logic [9:0]       pix_y,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic [RGB_W-1:0] vga_rgb,
    output logic             frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYN_E  = 10'(H_SYNC);
    localparam logic [9:0] V_SYN_E  = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_LO = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT_HI = 10'(H_SYNC + H_BACK + H_VALID - 1);
    localparam logic [9:0] H_REQ_LO = 10'(H_SYNC + H_BACK - 1);
    localparam logic [9:0] H_REQ_HI = 10'(H_SYNC + H_BACK + H_VALID - 2);
    localparam logic [9:0] V_ACT_LO = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT_HI = 10'(V_SYNC + V_BACK + V_VALID - 1);

    logic [9:0]       cnt_h_q, cnt_h_d;
    logic [9:0]       cnt_v_q, cnt_v_d;
    logic             hs_d, vs_d, act_d, req_d, fs_d, v_win;
    logic [RGB_W-1:0] rgb_d;
    logic             hs_q, vs_q, fs_q;
    logic [RGB_W-1:0] rgb_q;

    // Counter next state: line wraps at H_LAST, line count advances on wrap
    always_comb begin
        cnt_h_d = cnt_h_q + 10'd1;
        cnt_v_d = cnt_v_q;
        if (cnt_h_q == H_LAST) begin
            cnt_h_d = '0;
            cnt_v_d = (cnt_v_q == V_LAST) ? '0 : cnt_v_q + 10'd1;
        end
    end

    // Timing decode; the request window leads the active window by one pixel
    always_comb begin
        hs_d  = cnt_h_q < H_SYN_E;
        vs_d  = cnt_v_q < V_SYN_E;
        v_win = (cnt_v_q >= V_ACT_LO) && (cnt_v_q <= V_ACT_HI);
        act_d = v_win && (cnt_h_q >= H_ACT_LO) && (cnt_h_q <= H_ACT_HI);
        req_d = v_win && (cnt_h_q >= H_REQ_LO) && (cnt_h_q <= H_REQ_HI);
        fs_d  = (cnt_h_q == '0) && (cnt_v_q == '0);
        rgb_d = act_d ? pix_data : '0;
    end

    // Pixel request and coordinates of the pixel wanted next cycle
    always_comb begin
        pix_data_req = req_d;
        pix_x        = 10'h3FF;
        pix_y        = 10'h3FF;
        if (req_d) begin
            pix_x = cnt_h_q - H_REQ_LO;
            pix_y = cnt_v_q - V_ACT_LO;
        end
    end

    // Horizontal and vertical position counters
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_h_q <= '0;
            cnt_v_q <= '0;
        end else begin
            cnt_h_q <= cnt_h_d;
            cnt_v_q <= cnt_v_d;
        end
    end

    // Output registers, one cycle behind the decode
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            rgb_q <= '0;
            fs_q  <= 1'b0;
        end else begin
            hs_q  <= hs_d ? SYNC_POL : ~SYNC_POL;
            vs_q  <= vs_d ? SYNC_POL : ~SYNC_POL;
            rgb_q <= rgb_d;
            fs_q  <= fs_d;
        end
    end

    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_rgb     = rgb_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default 640x480 instance plus a tiny SYNC_POL=1 one,
// both checked every cycle against a position-from-time reference model.
module tb_vga_timing_gen;

    localparam int AHS = 96, AHB = 48, AHV = 640, AHF = 16;
    localparam int AVS = 2, AVB = 33, AVV = 480, AVF = 10;
    localparam int BHS = 4, BHB = 3, BHV = 8, BHF = 2;
    localparam int BVS = 2, BVB = 2, BVV = 4, BVF = 1;
    localparam int AHT = 800, AVT = 525;
    localparam int BHT = 17, BVT = 9;
    localparam int NV = 14;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pd_a, pd_b;
    logic        req_a, hs_a, vs_a, fs_a;
    logic        req_b, hs_b, vs_b, fs_b;
    logic [9:0]  x_a, y_a, x_b, y_b;
    logic [15:0] rgb_a, rgb_b;

    int t;
    int errors;
    int checks;

    logic       src_req;
    logic [9:0] src_x, src_y;

    logic hs_last, hs_valid;
    int   hs_run;
    logic vs_last, vs_valid;
    int   vs_run;
    int   fs_last_t;

    typedef struct {
        int          v;
        int          h;
        logic        req;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] rgb;
    } vec_t;

    vec_t vecs[NV];
    int   hits[NV];

    always #20 clk = ~clk;

    vga_timing_gen dut_a (
        .vga_clk(clk), .sys_rst(rst), .pix_data(pd_a),
        .pix_data_req(req_a), .pix_x(x_a), .pix_y(y_a),
        .vga_hs(hs_a), .vga_vs(vs_a), .vga_rgb(rgb_a),
        .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_SYNC(BHS), .H_BACK(BHB), .H_VALID(BHV), .H_FRONT(BHF),
        .V_SYNC(BVS), .V_BACK(BVB), .V_VALID(BVV), .V_FRONT(BVF),
        .SYNC_POL(1'b1), .RGB_W(16)
    ) dut_b (
        .vga_clk(clk), .sys_rst(rst), .pix_data(pd_b),
        .pix_data_req(req_b), .pix_x(x_b), .pix_y(y_b),
        .vga_hs(hs_b), .vga_vs(vs_b), .vga_rgb(rgb_b),
        .frame_start(fs_b)
    );

    function automatic void model(
        input  int tt, hs, hb, hv, hf, vs, vb, vv, vf,
        output logic req, output logic [9:0] x, output logic [9:0] y,
        output logic hsa, output logic vsa, output logic act,
        output logic fs, output int ax, output int ay
    );
        int ht, vt, h, v;
        logic vin;
        ht  = hs + hb + hv + hf;
        vt  = vs + vb + vv + vf;
        h   = tt % ht;
        v   = (tt / ht) % vt;
        hsa = h < hs;
        vsa = v < vs;
        vin = (v >= vs + vb) && (v < vs + vb + vv);
        act = vin && (h >= hs + hb) && (h < hs + hb + hv);
        req = vin && (h >= hs + hb - 1) && (h < hs + hb + hv - 1);
        x   = req ? 10'(h - (hs + hb - 1)) : 10'h3FF;
        y   = req ? 10'(v - (vs + vb)) : 10'h3FF;
        fs  = (h == 0) && (v == 0);
        ax  = h - (hs + hb);
        ay  = v - (vs + vb);
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0d", nm, got, exp, t);
        end
    endtask

    task automatic check_all();
        logic req, hsa, vsa, act, fs;
        logic [9:0] x, y;
        int ax, ay;
        logic [15:0] px;
        model(t, AHS, AHB, AHV, AHF, AVS, AVB, AVV, AVF,
              req, x, y, hsa, vsa, act, fs, ax, ay);
        chk("a_comb", {req_a, x_a, y_a}, {req, x, y});
        model(t, BHS, BHB, BHV, BHF, BVS, BVB, BVV, BVF,
              req, x, y, hsa, vsa, act, fs, ax, ay);
        chk("b_comb", {req_b, x_b, y_b}, {req, x, y});
        if (t == 0) begin
            chk("a_reg", {hs_a, vs_a, fs_a, rgb_a}, {3'b110, 16'h0});
            chk("b_reg", {hs_b, vs_b, fs_b, rgb_b}, {3'b000, 16'h0});
        end else begin
            model(t - 1, AHS, AHB, AHV, AHF, AVS, AVB, AVV, AVF,
                  req, x, y, hsa, vsa, act, fs, ax, ay);
            px = {6'(ay), 10'(ax)};
            chk("a_reg", {hs_a, vs_a, fs_a, rgb_a},
                {~hsa, ~vsa, fs, act ? px : 16'h0});
            model(t - 1, BHS, BHB, BHV, BHF, BVS, BVB, BVV, BVF,
                  req, x, y, hsa, vsa, act, fs, ax, ay);
            chk("b_reg", {hs_b, vs_b, fs_b, rgb_b},
                {hsa, vsa, fs, act ? pd_b : 16'h0});
        end
    endtask

    task automatic check_table();
        for (int i = 0; i < NV; i++) begin
            if (t % AHT == vecs[i].h && (t / AHT) % AVT == vecs[i].v) begin
                hits[i]++;
                chk("vec", {req_a, x_a, y_a, rgb_a},
                    {vecs[i].req, vecs[i].x, vecs[i].y, vecs[i].rgb});
            end
        end
    endtask

    task automatic measure();
        if (rst) begin
            hs_valid  = 1'b0;
            hs_last   = hs_a;
            vs_valid  = 1'b0;
            vs_last   = vs_b;
            fs_last_t = -1;
            return;
        end
        if (hs_a == hs_last) hs_run++;
        else begin
            if (hs_valid && hs_last) chk("a_hs_high_len", hs_run, 704);
            if (hs_valid && !hs_last) chk("a_hs_low_len", hs_run, 96);
            hs_valid = 1'b1;
            hs_run   = 1;
            hs_last  = hs_a;
        end
        if (vs_b == vs_last) vs_run++;
        else begin
            if (vs_valid && vs_last) chk("b_vs_pulse_len", vs_run, 2 * BHT);
            if (vs_valid && !vs_last) chk("b_vs_idle_len", vs_run, 7 * BHT);
            vs_valid = 1'b1;
            vs_run   = 1;
            vs_last  = vs_b;
        end
        if (fs_b) begin
            if (fs_last_t >= 0) chk("b_fs_period", t - fs_last_t, BHT * BVT);
            fs_last_t = t;
        end
    endtask

    task automatic step(input logic r);
        @(negedge clk);
        check_all();
        if (!rst) check_table();
        measure();
        pd_a    = src_req ? {src_y[5:0], src_x} : 16'($urandom);
        src_req = req_a;
        src_x   = x_a;
        src_y   = y_a;
        pd_b    = 16'($urandom);
        if (r && !rst) begin
            rst = 1'b1;
            #1;
            t = 0;
            chk("async_rst_a", {hs_a, vs_a, fs_a, rgb_a, req_a, x_a, y_a},
                {3'b110, 16'h0, 1'b0, 10'h3FF, 10'h3FF});
            chk("async_rst_b", {hs_b, vs_b, fs_b, rgb_b, req_b},
                {3'b000, 16'h0, 1'b0});
        end
        rst = r;
        @(posedge clk);
        t = rst ? 0 : t + 1;
    endtask

    initial begin
        vecs[0]  = '{35, 142, 1'b0, 10'h3FF, 10'h3FF, 16'h0000};
        vecs[1]  = '{35, 143, 1'b1, 10'd0,   10'd0,   16'h0000};
        vecs[2]  = '{35, 144, 1'b1, 10'd1,   10'd0,   16'h0000};
        vecs[3]  = '{35, 146, 1'b1, 10'd3,   10'd0,   16'h0001};
        vecs[4]  = '{35, 782, 1'b1, 10'd639, 10'd0,   16'h027D};
        vecs[5]  = '{35, 783, 1'b0, 10'h3FF, 10'h3FF, 16'h027E};
        vecs[6]  = '{35, 784, 1'b0, 10'h3FF, 10'h3FF, 16'h027F};
        vecs[7]  = '{35, 785, 1'b0, 10'h3FF, 10'h3FF, 16'h0000};
        vecs[8]  = '{36, 143, 1'b1, 10'd0,   10'd1,   16'h0000};
        vecs[9]  = '{36, 146, 1'b1, 10'd3,   10'd1,   16'h0401};
        vecs[10] = '{34, 500, 1'b0, 10'h3FF, 10'h3FF, 16'h0000};
        vecs[11] = '{37, 500, 1'b1, 10'd357, 10'd2,   16'h0963};
        vecs[12] = '{36, 784, 1'b0, 10'h3FF, 10'h3FF, 16'h067F};
        vecs[13] = '{0,  1,   1'b0, 10'h3FF, 10'h3FF, 16'h0000};
        for (int i = 0; i < NV; i++) hits[i] = 0;

        errors    = 0;
        checks    = 0;
        t         = 0;
        rst       = 1'b1;
        pd_a      = '0;
        pd_b      = '0;
        src_req   = 1'b0;
        src_x     = 10'h3FF;
        src_y     = 10'h3FF;
        hs_last   = 1'b1;
        hs_valid  = 1'b0;
        hs_run    = 0;
        vs_last   = 1'b0;
        vs_valid  = 1'b0;
        vs_run    = 0;
        fs_last_t = -1;

        repeat (3) step(1'b1);
        #1;
        chk("rst_hs", hs_a, 1'b1);
        chk("rst_vs", vs_a, 1'b1);
        chk("rst_rgb", rgb_a, 16'h0);
        chk("rst_req", req_a, 1'b0);
        chk("rst_x", x_a, 10'h3FF);

        step(1'b0);
        #1;
        chk("first_fs", fs_a, 1'b1);
        chk("first_hs", hs_a, 1'b0);
        chk("first_b_hs", hs_b, 1'b1);

        while (t < 37 * AHT + 500) step(1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        #1;
        chk("restart_fs", fs_a, 1'b1);
        chk("restart_hs", hs_a, 1'b0);
        chk("restart_vs", vs_a, 1'b0);

        repeat (2000) step(1'b0);

        for (int i = 0; i < NV; i++) chk("vec_hit", hits[i] != 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
